// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op and FSM state encodings for the sequential shifter
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift of WIDTH bits by 0..STEP under op
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int AW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amt,
    input  shift_op_e        op,
    input  logic             sign,
    output logic [WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] wide;

    // Right-side fills come from the upper half of a double-width word.
    always_comb begin
        wide = '0;
        res  = data;
        case (op)
            OP_SLL: res = data << amt;
            OP_SRL: res = data >> amt;
            OP_SRA: begin
                wide = {{WIDTH{sign}}, data} >> amt;
                res  = wide[WIDTH-1:0];
            end
            OP_ROR: begin
                wide = {data, data} >> amt;
                res  = wide[WIDTH-1:0];
            end
            default: res = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle variable shifter, STEP bits per clock with start/done handshake
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int AW = $clog2(STEP + 1);

    shift_state_e     state;
    shift_op_e        op_q;
    logic             sign_q;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] work;

    logic [AW-1:0]    step_amt;
    logic [SHW-1:0]   count_nxt;
    logic [WIDTH-1:0] step_out;

    always_comb begin
        step_amt = AW'(STEP);
        if (32'(count) < 32'(STEP)) begin
            step_amt = AW'(count);
        end
        count_nxt = count - SHW'(step_amt);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data (work),
        .amt  (step_amt),
        .op   (op_q),
        .sign (sign_q),
        .res  (step_out)
    );

    // IDLE and DONE share the acceptance path so back-to-back requests need no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_SLL;
            sign_q <= 1'b0;
            count  <= '0;
            work   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        work   <= data_in;
                        count  <= shamt;
                        op_q   <= shift_op_e'(op);
                        sign_q <= data_in[WIDTH-1];
                        if (shamt == '0) begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            result <= data_in;
                            busy   <= 1'b0;
                        end else begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work  <= step_out;
                    count <= count_nxt;
                    if (count_nxt == '0) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= step_out;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shift unit for the multicycle datapath. It generalises the fixed shift-left-by-2 into a variable-amount shifter. Supported operations are logical left, logical right, arithmetic right and rotate right, with a start/done handshake. Shifting proceeds STEP bits per clock, so a large WIDTH does not put a full barrel shifter on the critical path.

## Interface
- WIDTH, 32: data width; must be ≥ 2.
- STEP, 4: bits shifted per clock; power of two, 1 ≤ STEP ≤ WIDTH.
- SHW (localparam), $clog2(WIDTH): shift-amount width.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on a clk edge where busy=0.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- data_in  in  WIDTH  operand; sampled on acceptance.
- shamt  in  SHW  shift amount, 0..WIDTH-1; sampled on acceptance.
- busy  out  1  high while a shift is in progress.
- done  out  1  single-cycle pulse; result is valid.
- result  out  WIDTH  shifted value; held until the next acceptance.

## Operation
- Reset state: FSM in IDLE, busy=0, done=0, result=0, internal count=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: load the working register with data_in and the count with shamt; latch op.
  - shamt=0: go to DONE.
  - otherwise: go to SHIFT.
- SHIFT, per edge:
  - Shift the working register by s = min(count, STEP) using the latched op.
  - count -= s.
  - If the new count is 0, go to DONE; else stay in SHIFT.
- DONE: done=1 for exactly one cycle; result = working register. Next state:
  - start=1: accept a new request, same rules as IDLE (back-to-back operation).
  - otherwise: go to IDLE.
- busy = 1 in SHIFT only. A start while busy=1 is ignored with no side effects, and op, data_in and shamt changes are ignored.
- Per-op fill rules:
  - SLL: fill LSBs with 0.
  - SRL: fill MSBs with 0.
  - SRA: fill MSBs with the original bit WIDTH-1. Sign is preserved across every step.
  - ROR: bits leaving the LSB re-enter at the MSB.
- result updates only on the transition into DONE. It holds its value through IDLE and through any following SHIFT until the next DONE.
- Reset asserted mid-operation:
  - Immediately returns the FSM to IDLE and zeroes all outputs.
  - No done pulse is produced for the aborted request.

## Timing
- Let k = ceil(shamt/STEP).
- done is high in the cycle after the k-th clk edge following the accepting edge. For shamt=0 this is the cycle immediately after acceptance.
- Total latency, accepting edge to the edge that samples done: k+1 edges.
- Throughput: back-to-back requests are possible. Start presented during DONE is accepted on that edge with no idle gap.
- Worst case (WIDTH=32, STEP=4, shamt=31): k=8.
- STEP=WIDTH degenerates to a one-step barrel shifter with k ≤ 1.
- All outputs are registered; no combinational path exists from any input to any output.

## Structure
- Shared package shift_pkg holds:
  - op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROR;
  - FSM state encodings, so the decode stage and the bench use identical codes.
- Sub-module shift_step: combinational shift of WIDTH bits by 0..STEP under op, with sign input for SRA.
- The top level contains only the FSM, the count register and the working register.

## Test plan
Directed scenarios, WIDTH=32, STEP=4:
- SLL, data_in 0x00000001, shamt 2 -> result 0x00000004; done one edge after SHIFT entry (k=1); busy high one cycle.
- SRA, data_in 0x80000000, shamt 31 -> result 0xFFFFFFFF after k=8. SRL with the same operands -> 0x00000001.
- ROR, data_in 0x000000FF, shamt 4 -> 0xF000000F. ROR 0x12345678 by 16 -> 0x56781234.
- shamt 0, data_in 0xDEADBEEF, op SLL -> result 0xDEADBEEF; done in the cycle after acceptance; busy never asserts.
- Back-to-back requests:
  - start held through DONE with a second request (SLL 0x1 by 8) -> second accepted with no idle cycle; result 0x00000100.
  - start pulses during busy -> ignored.
- Reset mid-operation: rst_n low during SHIFT of a 31-bit SRA -> busy, done and result are 0 immediately; no done pulse after release; the next request completes normally.
